mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle main controller for the MIPS core. It replaces the single-cycle control unit when the `mips` top is converted to a shared-datapath multi-cycle machine, and it sequences PC, IR, GRF, ALU and DM through a FETCH/DECODE/EXEC/MEM/WB state machine. It supports addu, subu, ori, lw, sw, beq, lui, j, jal, jr and nop. It also emits a one-cycle retire pulse and keeps a retired-instruction counter for the testbench.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `op` input, 6 bits: IR[31:26]. It comes from the datapath IR register and is stable from DECODE onward.
- `funct` input, 6 bits: IR[5:0].
- `zero` input, 1 bit: ALU equal flag, valid in EXEC.
- `pc_we` output, 1 bit: PC write enable.
- `ir_we` output, 1 bit: IR write enable.
- `rf_we` output, 1 bit: GRF write enable.
- `dm_we` output, 1 bit: DM write enable.
- `npc_sel` output, 2 bits: next-PC source. 0 = PC+4, 1 = branch (PC + sext(imm)<<2, where PC already holds PC+4), 2 = j/jal target, 3 = rs (jr).
- `reg_dst` output, 2 bits: GRF write address. 0 = rt, 1 = rd, 2 = $31.
- `wd_sel` output, 2 bits: GRF write data. 0 = ALU result register, 1 = MDR, 2 = PC (already PC+4).
- `alu_src` output, 1 bit: ALU B input. 0 = rt, 1 = extended immediate.
- `ext_op` output, 2 bits: immediate extension. 0 = zero, 1 = sign, 2 = imm<<16.
- `alu_op` output, 3 bits: 0 = add, 1 = sub, 2 = or.
- `state` output, 3 bits: current state (debug).
- `retire` output, 1 bit: pulses for the final cycle of each instruction.
- `retire_cnt` output, `RETIRE_W` bits: count of retired instructions.

## Operation
- **States:** FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5–7 are illegal and go to FETCH.
- **FETCH:**
  - Asserts `ir_we=1`, `pc_we=1`, `npc_sel=0`.
  - Next state: DECODE.
- **DECODE:** classify `op`/`funct`.
  - j: `pc_we=1`, `npc_sel=2`. Retire, then go to FETCH.
  - jal: j signals plus `rf_we=1`, `reg_dst=2`, `wd_sel=2`. Retire, then go to FETCH.
  - jr (op=0, funct=001000): `pc_we=1`, `npc_sel=3`. Retire, then go to FETCH.
  - Unknown opcode or funct, including sll/nop: no enables asserted. Retire, then go to FETCH.
  - All other instructions: go to EXEC.
- **EXEC:** the ALU is driven per class.
  - addu: `alu_src=0`, `alu_op=0`. Next state WB.
  - subu: `alu_src=0`, `alu_op=1`. Next state WB.
  - ori: `alu_src=1`, `ext_op=0`, `alu_op=2`. Next state WB.
  - lui: `alu_src=1`, `ext_op=2`, `alu_op=2` (rs is $0 by encoding). Next state WB.
  - lw/sw: `alu_src=1`, `ext_op=1`, `alu_op=0`. Next state MEM.
  - beq: `alu_op=1`, `pc_we=zero`, `npc_sel=1`. Retire, then go to FETCH.
- **MEM:**
  - sw: `dm_we=1`. Retire, then go to FETCH.
  - lw: the datapath latches the MDR. Next state WB.
- **WB:** `rf_we=1`, then retire and go to FETCH.
  - R-type: `reg_dst=1`, `wd_sel=0`.
  - ori/lui: `reg_dst=0`, `wd_sel=0`.
  - lw: `reg_dst=0`, `wd_sel=1`.
- **Output defaults:** every output not listed for a state is 0.
- **Output timing:** outputs are combinational from `state`, `op`, `funct` and `zero` (Moore except the beq `pc_we`).
- **Retire counter:** `retire_cnt` increments on each edge where `retire=1`, and wraps modulo 2^`RETIRE_W`.

## Timing
- **Reset behaviour:**
  - On the edge where `reset=1`: state becomes FETCH and `retire_cnt` becomes 0.
  - While `reset=1`: `pc_we`, `ir_we`, `rf_we`, `dm_we` and `retire` are forced to 0 regardless of state.
  - Reset mid-instruction abandons the instruction with no GRF or DM write.
- **Cycle counts:**
  - j, jal, jr, nop/unknown: 2.
  - beq, sw: 3 and 4 respectively (beq: F, D, E; sw: F, D, E, M).
  - addu, subu, ori, lui: 4.
  - lw: 5.
- **Retire pulse:** `retire` is high in exactly one cycle per instruction, the last one. The counter value reflects that instruction from the following cycle.
- **FETCH:** never waits, with no stall input. The first FETCH after reset release uses the PC reset value supplied by the datapath.
- **beq not taken:** still takes 3 cycles, with `pc_we=0` in EXEC.

## Structure
- **Shared package `mips_defs`:**
  - opcode/funct constants;
  - state encoding;
  - NPC, REGDST, WDSEL, EXT and ALUOP select encodings.
  The datapath imports the same package.
- **Sub-module `instr_decode`:** combinational `op`/`funct` → one-hot instruction class, with `unknown` as a class.
- **`mc_ctrl`:** holds the state register, output logic and retire counter.

## Test plan
- **Reset:** assert `reset` for 2 cycles while the machine is in WB with `rf_we` active.
  - During reset: `rf_we`=0.
  - After reset: `state`=0, `retire_cnt`=0, and the next cycle is DECODE.
- **addu (op=0, funct=100001):** `state` sequence 0,1,2,4,0.
  - WB: `rf_we`=1, `reg_dst`=1, `wd_sel`=0.
  - `retire` high only in WB; `retire_cnt` then reads 1.
- **lw (op=100011):** 5 cycles.
  - EXEC: `ext_op`=1, `alu_src`=1.
  - WB: `wd_sel`=1, `reg_dst`=0.
- **sw (op=101011):** 4 cycles, with `dm_we`=1 only in MEM.
- **beq (op=000100):**
  - With `zero`=1: `pc_we`=1 and `npc_sel`=1 in EXEC.
  - With `zero`=0: `pc_we`=0.
  - Both cases: 3 cycles.
- **Jumps and unknown opcode:**
  - jal (op=000011): in DECODE `pc_we`=1, `npc_sel`=2, `rf_we`=1, `reg_dst`=2, `wd_sel`=2.
  - Unknown op=111111: 2 cycles, no enables, `retire_cnt` still increments.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS encodings: opcodes, functs, controller states, datapath select codes
// and the one-hot instruction class produced by instr_decode.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_RS     = 2'd3;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_RA  = 2'd2;

  localparam logic [1:0] WDSEL_ALU  = 2'd0;
  localparam logic [1:0] WDSEL_MDR  = 2'd1;
  localparam logic [1:0] WDSEL_PC   = 2'd2;

  localparam logic [1:0] EXT_ZERO   = 2'd0;
  localparam logic [1:0] EXT_SIGN   = 2'd1;
  localparam logic [1:0] EXT_HIGH   = 2'd2;

  localparam logic [2:0] ALUOP_ADD  = 3'd0;
  localparam logic [2:0] ALUOP_SUB  = 3'd1;
  localparam logic [2:0] ALUOP_OR   = 3'd2;

  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic unknown;
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and ALU flag in, enables and selects out.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pc_we;
  logic       ir_we;
  logic       rf_we;
  logic       dm_we;
  logic [1:0] npc_sel;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic       alu_src;
  logic [1:0] ext_op;
  logic [2:0] alu_op;

  modport master (
    input  op, funct, zero,
    output pc_we, ir_we, rf_we, dm_we, npc_sel, reg_dst, wd_sel, alu_src, ext_op, alu_op
  );

  modport slave (
    output op, funct, zero,
    input  pc_we, ir_we, rf_we, dm_we, npc_sel, reg_dst, wd_sel, alu_src, ext_op, alu_op
  );
endinterface

// File: rtl/instr_decode.sv
// Combinational op/funct classifier; anything unsupported (sll/nop included) is 'unknown'.
module instr_decode
  import mips_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  always_comb begin
    // NOTE: default every field first so no path leaves cls unassigned (no latch).
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.addu    = 1'b1;
          FN_SUBU: cls.subu    = 1'b1;
          FN_JR:   cls.jr      = 1'b1;
          default: cls.unknown = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_J:    cls.j       = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencer with retire pulse
// and retired-instruction counter.
module mc_ctrl
  import mips_defs::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  mc_ctrl_if.master           bus,
  output logic [2:0]          state,
  output logic                retire,
  output logic [RETIRE_W-1:0] retire_cnt
);

  state_e  cur, nxt;
  iclass_t cls;

  instr_decode u_decode (
    .op    (bus.op),
    .funct (bus.funct),
    .cls   (cls)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: if (!(cls.j || cls.jal || cls.jr || cls.unknown)) nxt = S_EXEC;
      S_EXEC: begin
        if (cls.lw || cls.sw)                              nxt = S_MEM;
        else if (cls.addu || cls.subu || cls.ori || cls.lui) nxt = S_WB;
      end
      S_MEM:    if (cls.lw) nxt = S_WB;
      default:  nxt = S_FETCH;
    endcase
  end

  always_comb begin
    bus.pc_we   = 1'b0;
    bus.ir_we   = 1'b0;
    bus.rf_we   = 1'b0;
    bus.dm_we   = 1'b0;
    bus.npc_sel = NPC_PC4;
    bus.reg_dst = REGDST_RT;
    bus.wd_sel  = WDSEL_ALU;
    bus.alu_src = 1'b0;
    bus.ext_op  = EXT_ZERO;
    bus.alu_op  = ALUOP_ADD;
    retire      = 1'b0;
    case (cur)
      S_FETCH: begin
        bus.ir_we = 1'b1;
        bus.pc_we = 1'b1;
      end
      S_DECODE: begin
        if (cls.j || cls.jal) begin
          bus.pc_we   = 1'b1;
          bus.npc_sel = NPC_JUMP;
        end
        if (cls.jal) begin
          bus.rf_we   = 1'b1;
          bus.reg_dst = REGDST_RA;
          bus.wd_sel  = WDSEL_PC;
        end
        if (cls.jr) begin
          bus.pc_we   = 1'b1;
          bus.npc_sel = NPC_RS;
        end
        retire = cls.j || cls.jal || cls.jr || cls.unknown;
      end
      S_EXEC: begin
        if (cls.subu) bus.alu_op = ALUOP_SUB;
        if (cls.ori || cls.lui) begin
          bus.alu_src = 1'b1;
          bus.alu_op  = ALUOP_OR;
          bus.ext_op  = cls.lui ? EXT_HIGH : EXT_ZERO;
        end
        if (cls.lw || cls.sw) begin
          bus.alu_src = 1'b1;
          bus.ext_op  = EXT_SIGN;
        end
        // Only beq's PC write depends on a live datapath flag.
        if (cls.beq) begin
          bus.alu_op  = ALUOP_SUB;
          bus.pc_we   = bus.zero;
          bus.npc_sel = NPC_BRANCH;
          retire      = 1'b1;
        end
      end
      S_MEM: begin
        bus.dm_we = cls.sw;
        retire    = cls.sw;
      end
      S_WB: begin
        bus.rf_we   = 1'b1;
        bus.reg_dst = (cls.addu || cls.subu) ? REGDST_RD : REGDST_RT;
        bus.wd_sel  = cls.lw ? WDSEL_MDR : WDSEL_ALU;
        retire      = 1'b1;
      end
      default: ;
    endcase
    // A reset cycle must never commit architectural state, whatever the FSM shows.
    if (reset) begin
      bus.pc_we = 1'b0;
      bus.ir_we = 1'b0;
      bus.rf_we = 1'b0;
      bus.dm_we = 1'b0;
      retire    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + 1'b1;
  end

  assign state = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction state walks, control snapshots,
// retire counting with wrap (4-bit counter), and reset abandoning a WB.
module tb_mc_ctrl;

  logic       clk;
  logic       reset;
  logic [2:0] state;
  logic       retire;
  logic [3:0] retire_cnt;

  mc_ctrl_if bus ();

  mc_ctrl #(.RETIRE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.master),
    .state      (state),
    .retire     (retire),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       rf_we;
    logic       dm_we;
    logic [1:0] npc_sel;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic       retire;
    logic [2:0] state;
  } snap_t;

  snap_t      snap [8];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic snap_t grab();
    snap_t s;
    s.pc_we   = bus.pc_we;
    s.ir_we   = bus.ir_we;
    s.rf_we   = bus.rf_we;
    s.dm_we   = bus.dm_we;
    s.npc_sel = bus.npc_sel;
    s.reg_dst = bus.reg_dst;
    s.wd_sel  = bus.wd_sel;
    s.alu_src = bus.alu_src;
    s.ext_op  = bus.ext_op;
    s.alu_op  = bus.alu_op;
    s.retire  = retire;
    s.state   = state;
    return s;
  endfunction

  function automatic logic [14:0] sq(input int a, input int b, input int c, input int d, input int e);
    logic [2:0] va, vb, vc, vd, ve;
    va = a[2:0]; vb = b[2:0]; vc = c[2:0]; vd = d[2:0]; ve = e[2:0];
    return {ve, vd, vc, vb, va};
  endfunction

  // Runs one instruction from FETCH until its retire cycle (bounded), then one more
  // edge to observe the counter and the return to FETCH.
  task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int exp_cyc, input logic [14:0] exp_seq);
    int          c;
    int          cycles;
    bit          done;
    logic [14:0] seq;
    bus.op    = o;
    bus.funct = f;
    bus.zero  = z;
    seq  = '0;
    c    = 0;
    done = 1'b0;
    while (!done && c < 8) begin
      snap[c] = grab();
      if (c < 5) seq[3*c +: 3] = state;
      if (snap[c].retire) done = 1'b1;
      else begin
        step();
        c++;
      end
    end
    cycles = done ? c + 1 : c;
    check({tag, "_cycles"}, cycles, exp_cyc);
    check({tag, "_states"}, {17'd0, seq}, {17'd0, exp_seq});
    check({tag, "_fetch_en"}, {snap[0].ir_we, snap[0].pc_we}, 2'b11);
    step();
    exp_cnt = exp_cnt + 4'd1;
    check({tag, "_cnt"}, retire_cnt, exp_cnt);
    check({tag, "_back_fetch"}, state, 3'd0);
  endtask

  initial begin
    bus.op    = 6'd0;
    bus.funct = 6'd0;
    bus.zero  = 1'b0;
    exp_cnt   = 4'd0;
    reset     = 1'b1;
    step();
    step();
    check("rst_state", state, 3'd0);
    check("rst_cnt", retire_cnt, 4'd0);
    check("rst_enables", {bus.pc_we, bus.ir_we, bus.rf_we, bus.dm_we, retire}, 5'd0);
    reset = 1'b0;
    #1;

    run_instr("addu", 6'b000000, 6'b100001, 1'b0, 4, sq(0, 1, 2, 4, 0));
    check("addu_exec_alu", {snap[2].alu_src, snap[2].alu_op}, 4'b0_000);
    check("addu_wb", {snap[3].rf_we, snap[3].reg_dst, snap[3].wd_sel}, 5'b1_01_00);
    check("addu_no_early_retire", {snap[0].retire, snap[1].retire, snap[2].retire}, 3'b000);

    run_instr("subu", 6'b000000, 6'b100011, 1'b0, 4, sq(0, 1, 2, 4, 0));
    check("subu_exec_alu", {snap[2].alu_src, snap[2].alu_op}, 4'b0_001);

    run_instr("ori", 6'b001101, 6'b000000, 1'b0, 4, sq(0, 1, 2, 4, 0));
    check("ori_exec", {snap[2].alu_src, snap[2].ext_op, snap[2].alu_op}, 6'b1_00_010);
    check("ori_wb", {snap[3].rf_we, snap[3].reg_dst, snap[3].wd_sel}, 5'b1_00_00);

    run_instr("lui", 6'b001111, 6'b000000, 1'b0, 4, sq(0, 1, 2, 4, 0));
    check("lui_exec", {snap[2].alu_src, snap[2].ext_op, snap[2].alu_op}, 6'b1_10_010);

    run_instr("lw", 6'b100011, 6'b000000, 1'b0, 5, sq(0, 1, 2, 3, 4));
    check("lw_exec", {snap[2].alu_src, snap[2].ext_op, snap[2].alu_op}, 6'b1_01_000);
    check("lw_mem_quiet", {snap[3].dm_we, snap[3].rf_we, snap[3].retire}, 3'b000);
    check("lw_wb", {snap[4].rf_we, snap[4].reg_dst, snap[4].wd_sel}, 5'b1_00_01);

    run_instr("sw", 6'b101011, 6'b000000, 1'b0, 4, sq(0, 1, 2, 3, 0));
    check("sw_exec_dm", snap[2].dm_we, 1'b0);
    check("sw_mem_dm", snap[3].dm_we, 1'b1);
    check("sw_no_rf", {snap[1].rf_we, snap[2].rf_we, snap[3].rf_we}, 3'b000);

    run_instr("beq_t", 6'b000100, 6'b000000, 1'b1, 3, sq(0, 1, 2, 0, 0));
    check("beq_t_exec", {snap[2].pc_we, snap[2].npc_sel, snap[2].alu_op}, 6'b1_01_001);

    run_instr("beq_nt", 6'b000100, 6'b000000, 1'b0, 3, sq(0, 1, 2, 0, 0));
    check("beq_nt_pc_we", snap[2].pc_we, 1'b0);

    run_instr("jal", 6'b000011, 6'b000000, 1'b0, 2, sq(0, 1, 0, 0, 0));
    check("jal_decode", {snap[1].pc_we, snap[1].npc_sel, snap[1].rf_we, snap[1].reg_dst,
                         snap[1].wd_sel}, 8'b1_10_1_10_10);

    run_instr("j", 6'b000010, 6'b000000, 1'b0, 2, sq(0, 1, 0, 0, 0));
    check("j_decode", {snap[1].pc_we, snap[1].npc_sel, snap[1].rf_we}, 4'b1_10_0);

    run_instr("jr", 6'b000000, 6'b001000, 1'b0, 2, sq(0, 1, 0, 0, 0));
    check("jr_decode", {snap[1].pc_we, snap[1].npc_sel}, 3'b1_11);

    run_instr("unk", 6'b111111, 6'b000000, 1'b0, 2, sq(0, 1, 0, 0, 0));
    check("unk_no_en", {snap[1].pc_we, snap[1].ir_we, snap[1].rf_we, snap[1].dm_we}, 4'b0000);

    run_instr("nop", 6'b000000, 6'b000000, 1'b0, 2, sq(0, 1, 0, 0, 0));
    check("nop_no_en", {snap[1].pc_we, snap[1].ir_we, snap[1].rf_we, snap[1].dm_we}, 4'b0000);

    // 13 retired so far; three more wrap the 4-bit counter to zero.
    for (int i = 0; i < 3; i++) run_instr("pad", 6'b111111, 6'b000000, 1'b0, 2, sq(0, 1, 0, 0, 0));
    check("cnt_wrap", retire_cnt, 4'd0);

    // Reset while addu sits in WB with rf_we active.
    bus.op    = 6'b000000;
    bus.funct = 6'b100001;
    step();
    step();
    step();
    check("pre_rst_wb_state", state, 3'd4);
    check("pre_rst_rf_we", bus.rf_we, 1'b1);
    reset = 1'b1;
    #1;
    check("in_rst_rf_we", bus.rf_we, 1'b0);
    check("in_rst_retire", retire, 1'b0);
    step();
    check("in_rst_pc_ir", {bus.pc_we, bus.ir_we}, 2'b00);
    step();
    reset = 1'b0;
    #1;
    check("post_rst_state", state, 3'd0);
    check("post_rst_cnt", retire_cnt, 4'd0);
    step();
    check("post_rst_decode", state, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
